// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015) block cipher core:
// S-box tables, round function, key schedule and FSM state type.
package magma_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // key_t[7] holds K1 (key[255:224]) and key_t[0] holds K8.
    typedef logic [7:0][31:0] key_t;

    localparam logic [3:0] PI [0:7][0:15] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    function automatic logic [31:0] magma_g(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] t;
        logic [31:0] s;
        t = a + k;
        s = '0;
        for (int i = 0; i < 8; i++) s[4*i +: 4] = PI[i][t[4*i +: 4]];
        return {s[20:0], s[31:21]};
    endfunction

    // Returns the 0-based subkey number (0 = K1 .. 7 = K8) for a round.
    function automatic logic [2:0] magma_key_idx(input logic [4:0] rnd, input logic dec);
        logic [4:0] r;
        r = dec ? 5'd31 - rnd : rnd;
        return (r < 5'd24) ? r[2:0] : 3'd7 - r[2:0];
    endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma Feistel round: (L,R) -> (R, L ^ g(k,R)).
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [31:0] k,
    output logic [31:0] l_nxt,
    output logic [31:0] r_nxt
);

    assign l_nxt = r;
    assign r_nxt = l ^ magma_g(k, r);

endmodule

// File: rtl/magma_cipher_core.sv
// Magma 64-bit block cipher core, ROUNDS_PER_CYCLE unrolled rounds per clock,
// valid/ready on input and output.
module magma_cipher_core
    import magma_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [63:0]  data_in,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16 || RPC == 32)) begin : g_bad_rpc
        $error("magma_cipher_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nxt;
    logic        last;
    logic        accept;
    logic [31:0] l_q, r_q;
    key_t        key_q;
    logic        dec_q;

    logic [RPC:0][31:0]   l_ch, r_ch;
    logic [RPC-1:0][31:0] k_ch;

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;

    // Round chain: stage j evaluates absolute round cnt+j, which stays below 32 in RUN.
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        assign k_ch[j] = key_q[3'd7 - magma_key_idx(cnt[4:0] + 5'(j), dec_q)];
        magma_round u_round (
            .l     (l_ch[j]),
            .r     (r_ch[j]),
            .k     (k_ch[j]),
            .l_nxt (l_ch[j+1]),
            .r_nxt (r_ch[j+1])
        );
    end

    assign cnt_nxt   = cnt + 6'(RPC);
    assign last      = (cnt_nxt == 6'd32);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            cnt      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nxt;
            // Registered so it stays low for the first clock after reset release.
            in_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: if (accept) begin
                    l_q   <= data_in[63:32];
                    r_q   <= data_in[31:0];
                    key_q <= key;
                    dec_q <= decrypt;
                    cnt   <= '0;
                end
                RUN: begin
                    l_q <= l_ch[RPC];
                    r_q <= r_ch[RPC];
                    cnt <= cnt_nxt;
                    if (last) data_out <= {r_ch[RPC], l_ch[RPC]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_magma_cipher_core.sv
// Randomised self-checking bench for magma_cipher_core at 1, 4 and 32 rounds/cycle.
module tb_magma_cipher_core;

    localparam int NDUT = 3;
    localparam logic [255:0] KEY_STD = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  PT_STD  = 64'hfedcba9876543210;
    localparam logic [63:0]  CT_STD  = 64'h4ee901e5c2d8ca3d;

    function automatic int rpc(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 32);
    endfunction

    localparam int PI_T [8][16] = '{
        '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
        '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
        '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
        '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
        '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
        '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
        '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
        '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
    };

    logic         clk = 1'b0;
    logic         reset_;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic         decrypt   [NDUT];
    logic [63:0]  data_in   [NDUT];
    logic [255:0] key       [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [63:0]  data_out  [NDUT];

    int total = 0;
    int bad   = 0;
    int hold_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        magma_cipher_core #(.ROUNDS_PER_CYCLE(rpc(g))) u_dut (
            .clk       (clk),
            .reset_    (reset_),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .decrypt   (decrypt[g]),
            .data_in   (data_in[g]),
            .key       (key[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Reference: build the 32-entry subkey schedule, then run the Feistel network.
    function automatic logic [63:0] ref_magma(input logic [255:0] k, input logic [63:0] blk, input logic dec);
        logic [31:0] rk [32];
        logic [31:0] a1, a0, t, s, nxt;
        int n;
        for (int r = 0; r < 32; r++) begin
            n = (r < 24) ? (r % 8) : (7 - r % 8);
            rk[r] = k[255 - 32*n -: 32];
        end
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            t = a0 + (dec ? rk[31-i] : rk[i]);
            for (int b = 0; b < 8; b++) s[4*b +: 4] = 4'(PI_T[b][int'(t[4*b +: 4])]);
            s   = (s << 11) | (s >> 21);
            nxt = a1 ^ s;
            a1  = a0;
            a0  = nxt;
        end
        return {a0, a1};
    endfunction

    task automatic scramble(input int d);
        in_valid[d] = 1'($urandom);
        decrypt[d]  = 1'($urandom);
        data_in[d]  = {$urandom, $urandom};
        key[d]      = rand256();
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(in_ready[d]), 64'd1);
    endtask

    task automatic run_block(input int d, input logic [255:0] k, input logic [63:0] din,
                             input logic dec, input int stall,
                             output logic [63:0] res, output int lat);
        in_valid[d] = 1'b1;
        key[d]      = k;
        data_in[d]  = din;
        decrypt[d]  = dec;
        wait_ready(d);
        @(negedge clk);
        in_valid[d] = 1'b0;
        data_in[d]  = {$urandom, $urandom};
        key[d]      = rand256();
        decrypt[d]  = 1'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("out_valid_timeout", 64'(out_valid[d]), 64'd1);
        res = data_out[d];
        repeat (stall) begin
            @(negedge clk);
            if (data_out[d] !== res || !out_valid[d] || in_ready[d]) hold_bad++;
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        if (!in_ready[d] || out_valid[d]) hold_bad++;
    endtask

    initial begin
        logic [63:0] res, res2, pt;
        logic [255:0] k;
        logic dec;
        int lat, viol, n;

        reset_ = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; decrypt[d] = 1'b0; data_in[d] = '0; key[d] = '0; out_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
            chk("rst_data_out",  data_out[d],       64'd0);
            chk("rst_in_ready",  64'(in_ready[d]),  64'd0);
        end
        reset_ = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk("in_ready_after_rst", 64'(in_ready[d]), 64'd1);

        // Standard vector, decrypt and all-ones carry case on every unroll factor.
        for (int d = 0; d < NDUT; d++) begin
            run_block(d, KEY_STD, PT_STD, 1'b0, 0, res, lat);
            chk("enc_std", res, CT_STD);
            chk("enc_lat", 64'(lat), 64'(32 / rpc(d)));
            run_block(d, KEY_STD, CT_STD, 1'b1, 0, res, lat);
            chk("dec_std", res, PT_STD);
            chk("dec_lat", 64'(lat), 64'(32 / rpc(d)));
            run_block(d, '1, '1, 1'b0, 1, res, lat);
            chk("carry_enc", res, ref_magma('1, '1, 1'b0));
            run_block(d, '1, '1, 1'b1, 0, res, lat);
            chk("carry_dec", res, ref_magma('1, '1, 1'b1));
        end

        // Back-pressure with input churn during RUN and DONE.
        viol = 0;
        in_valid[0] = 1'b1; key[0] = KEY_STD; data_in[0] = PT_STD; decrypt[0] = 1'b0;
        wait_ready(0);
        @(negedge clk);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            scramble(0);
            @(negedge clk);
            if (in_ready[0]) viol++;
            n++;
        end
        if (n >= 100) chk("bp_out_valid_timeout", 64'(out_valid[0]), 64'd1);
        repeat (10) begin
            scramble(0);
            @(negedge clk);
            if (in_ready[0] || !out_valid[0] || data_out[0] !== CT_STD) viol++;
        end
        chk("bp_violations", 64'(viol), 64'd0);
        chk("bp_data", data_out[0], CT_STD);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_no_second_accept", {62'd0, in_ready[0], out_valid[0]}, 64'd2);

        // Reset during round 16 aborts with no output.
        in_valid[0] = 1'b1; key[0] = KEY_STD; data_in[0] = PT_STD; decrypt[0] = 1'b0;
        wait_ready(0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (16) @(negedge clk);
        reset_ = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("midrst_data_out",  data_out[0],       64'd0);
        chk("midrst_in_ready",  64'(in_ready[0]),  64'd0);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        chk("midrst_no_output", 64'(out_valid[0]), 64'd0);
        run_block(0, KEY_STD, PT_STD, 1'b0, 0, res, lat);
        chk("midrst_fresh_enc", res, CT_STD);

        // Random stream of encrypt/decrypt pairs with stalls.
        for (int i = 0; i < 50; i++) begin
            int d;
            d   = (i % 5 == 0) ? 0 : 1;
            k   = rand256();
            pt  = {$urandom, $urandom};
            dec = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_block(d, k, pt, dec, $urandom_range(0, 3), res, lat);
            chk("stream_first", res, ref_magma(k, pt, dec));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_block(d, k, res, !dec, $urandom_range(0, 3), res2, lat);
            chk("stream_roundtrip", res2, pt);
        end
        chk("hold_and_handshake", 64'(hold_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magma_cipher_core.md
# magma_cipher_core

Parametrised GOST R 34.12-2015 "Magma" 64-bit block cipher core with encrypt and decrypt modes, valid/ready handshakes on both sides, and a configurable number of Feistel rounds per clock. It is the next-generation replacement for the single-round, start/done Magma engine. It sits between the key/data front end and the mode-of-operation wrapper (ECB/CTR/MAC).

## Interface
- ROUNDS_PER_CYCLE, 1, Feistel rounds evaluated per clock.
  - Legal values: 1, 2, 4, 8, 16, 32.
  - Any other value is an elaboration error.
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block and key valid.
- in_ready  out  1  core can accept a block.
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- data_in  in  64  block; [63:32] = a1 (left), [31:0] = a0 (right).
- key  in  256  key; K1 = key[255:224] … K8 = key[31:0]; sampled on accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- data_out  out  64  result block.

## Operation
- Round function:
  - g(k,a) = rotl11(S(a + k mod 2^32)).
  - S maps nibble i (bits 4i+3:4i) through pi_i, i = 0..7.
  - pi tables are the standard Magma tables; pi0 = 12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1.
- Round step: (L,R) -> (R, L xor g(k,R)).
  - After 32 rounds, data_out = {R,L}, i.e. the final swap is undone.
- Key index for round r (0..31), encrypt:
  - r < 24: K(r mod 8 + 1).
  - r >= 24: K(8 − r mod 8).
- Decrypt uses the encrypt index of round 31−r.
- Addition is 32-bit modular; the carry is discarded.
- FSM states:
  - IDLE: in_ready = 1.
    - On in_valid, latch {L,R}, key, decrypt; clear the round counter; go to RUN.
  - RUN: each cycle applies ROUNDS_PER_CYCLE consecutive rounds and advances the counter by ROUNDS_PER_CYCLE.
    - When the counter reaches 32, go to DONE.
  - DONE: out_valid = 1 and data_out is stable.
    - On out_ready, go to IDLE.
- in_ready is deasserted in RUN and DONE. Inputs there are ignored, including changes to key, decrypt or data_in.
- out_valid must not depend combinationally on out_ready.
- The round counter is 6 bits wide and never wraps: 32 is its terminal value.
- Reset is legal at any time, including mid-RUN or in DONE.
  - It aborts the operation with no output.
  - Reset values: state IDLE, in_ready 0 while reset_ is low, out_valid 0, data_out 0, internal L/R/key 0.
  - in_ready rises on the first clk after reset deassertion.

## Timing
- Accept edge t (in_valid && in_ready) -> out_valid high after edge t + 32/ROUNDS_PER_CYCLE:
  - 32 cycles at R=1.
  - 4 cycles at R=8.
  - 1 cycle at R=32.
- Output handshake at edge u -> in_ready high after edge u.
  - The next accept occurs at edge u+1 at the earliest.
- Throughput: one block per 32/ROUNDS_PER_CYCLE + 2 cycles with out_ready held high.
- Back-pressure: out_valid and data_out hold indefinitely while out_ready = 0.
- The critical path scales with ROUNDS_PER_CYCLE. At R >= 8, a timing margin of one cycle per 8 rounds is accepted.

## Structure
- Package magma_pkg holds:
  - the eight pi S-box constants;
  - function magma_g(k,a);
  - function magma_key_idx(round, decrypt);
  - state enum typedef {IDLE, RUN, DONE}.
- Sub-module magma_round: purely combinational single round.
  - Inputs: L, R, k. Outputs: L', R'.
  - Instantiated ROUNDS_PER_CYCLE times in a generate chain.
  - Each instance's key is selected by magma_key_idx(cnt + j, decrypt).
- Top level: FSM, latched operands, counter, output register.

## Test plan
- Encrypt, standard vector:
  - Stimulus: key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data fedcba9876543210, decrypt 0, out_ready 1.
  - Required: data_out 4ee901e5c2d8ca3d, out_valid exactly 32/R cycles after accept. Run for R = 1, 4, 32.
- Decrypt:
  - Stimulus: same key, data 4ee901e5c2d8ca3d, decrypt 1.
  - Required: data_out fedcba9876543210.
- Back-pressure:
  - Stimulus: hold out_ready 0 for 10 cycles after out_valid; toggle in_valid, data_in and key during RUN and DONE.
  - Required: data_out stays 4ee901e5c2d8ca3d; in_ready stays 0; no second accept.
- Mid-operation reset:
  - Stimulus: assert reset_ low during round 16.
  - Required: out_valid 0, data_out 0. A fresh encrypt of the standard vector afterwards gives the correct result.
- Back-to-back stream:
  - Stimulus: 100 random blocks/keys/modes with random in_valid/out_ready stalls.
  - Required: matches the reference model. Each encrypt-then-decrypt pair returns the plaintext.
- Modular carry:
  - Stimulus: key all-ones, data all-ones.
  - Required: matches the reference model, exercising addition overflow in every round.
